ascon_permutation: RTL and testbench

- Iterative Ascon-p[rnd] permutation core per SP 800-232. Computes one round per clock: constant addition, then substitution, then the existing combinational diffusion layer.
- Sits between the mode controllers (AEAD/hash/XOF) and the round logic. It accepts a 320-bit state plus a round count and returns the permuted state.
- Uses a valid/ready handshake on both sides.

---
 rtl/ascon_pkg.sv | 33 +++
 rtl/ascon_diffusion.sv | 23 ++
 rtl/ascon_round.sv | 39 +++
 rtl/ascon_permutation.sv | 90 +++++++++
 tb/tb_ascon_permutation.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared widths, constant tables and FSM encoding for the Ascon permutation
package ascon_pkg;

  localparam int ASCON_STATE_W = 320;
  localparam int ASCON_WORD_W  = 64;

  // Round constants; a job of n rounds uses the last n entries.
  localparam logic [7:0] ASCON_RC [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  // 5-bit S-box, index and result both ordered {x0,x1,x2,x3,x4} with x0 as MSB.
  localparam logic [4:0] ASCON_SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ascon_fsm_e;

  // Rotate a 64-bit word right by a constant amount.
  function automatic logic [ASCON_WORD_W-1:0] ror64(input logic [ASCON_WORD_W-1:0] v,
                                                    input int unsigned n);
    return (v >> n) | (v << (ASCON_WORD_W - n));
  endfunction

endpackage

// File: rtl/ascon_diffusion.sv
// rtl/ascon_diffusion.sv - linear diffusion layer: each word XORed with two rotations of itself
module ascon_diffusion
  import ascon_pkg::*;
(
  input  logic [ASCON_STATE_W-1:0] state_i,
  output logic [ASCON_STATE_W-1:0] state_o
);

  logic [ASCON_WORD_W-1:0] s0, s1, s2, s3, s4;

  assign s0 = state_i[0   +: ASCON_WORD_W];
  assign s1 = state_i[64  +: ASCON_WORD_W];
  assign s2 = state_i[128 +: ASCON_WORD_W];
  assign s3 = state_i[192 +: ASCON_WORD_W];
  assign s4 = state_i[256 +: ASCON_WORD_W];

  assign state_o[0   +: ASCON_WORD_W] = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign state_o[64  +: ASCON_WORD_W] = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign state_o[128 +: ASCON_WORD_W] = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign state_o[192 +: ASCON_WORD_W] = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign state_o[256 +: ASCON_WORD_W] = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);

endmodule

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant add, bit-sliced S-box, diffusion
module ascon_round
  import ascon_pkg::*;
(
  input  logic [ASCON_STATE_W-1:0] state_i,
  input  logic [7:0]               rc_i,
  output logic [ASCON_STATE_W-1:0] state_o
);

  logic [ASCON_STATE_W-1:0] added;
  logic [ASCON_STATE_W-1:0] subst;
  logic [4:0]               col;

  // Constant only touches the low byte of s2.
  always_comb begin
    added             = state_i;
    added[128 +: 8]   = state_i[128 +: 8] ^ rc_i;
  end

  // Column j gathers bit j of every word, x0 (from s0) in the MSB of the S-box index.
  always_comb begin
    subst = '0;
    col   = '0;
    for (int j = 0; j < ASCON_WORD_W; j++) begin
      col = ASCON_SBOX[{added[j], added[64+j], added[128+j], added[192+j], added[256+j]}];
      subst[j]       = col[4];
      subst[64+j]    = col[3];
      subst[128+j]   = col[2];
      subst[192+j]   = col[1];
      subst[256+j]   = col[0];
    end
  end

  ascon_diffusion u_diffusion (
    .state_i (subst),
    .state_o (state_o)
  );

endmodule

// File: rtl/ascon_permutation.sv
// rtl/ascon_permutation.sv - iterative Ascon-p[rnd] core, one round per clock, valid/ready on both sides
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = 16,
  parameter int RND_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ASCON_STATE_W-1:0] state_in,
  input  logic [RND_W-1:0]         rnd_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ASCON_STATE_W-1:0] state_out,
  output logic                     busy
);

  localparam int IDX_W = $clog2(MAX_ROUNDS);

  ascon_fsm_e               fsm_q, fsm_d;
  logic [ASCON_STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [RND_W-1:0]         rem_q, rem_d;
  logic [RND_W-1:0]         rnd_eff;
  logic [ASCON_STATE_W-1:0] round_state;

  // Requests beyond the table length run the full table.
  assign rnd_eff = (rnd_in > RND_W'(MAX_ROUNDS)) ? RND_W'(MAX_ROUNDS) : rnd_in;

  ascon_round u_round (
    .state_i (state_q),
    .rc_i    (ASCON_RC[idx_q]),
    .state_o (round_state)
  );

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_RUN);
  assign state_out = state_q;

  // Next-state: accept in IDLE, iterate in RUN, hold the result in DONE until taken.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = state_in;
          idx_d   = IDX_W'(RND_W'(MAX_ROUNDS) - rnd_eff);
          rem_d   = rnd_eff;
          fsm_d   = (rnd_eff == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_state;
        idx_d   = idx_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        if (rem_q == RND_W'(1)) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset that discards any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_ascon_permutation.sv
// tb/tb_ascon_permutation.sv - self-checking bench for ascon_permutation against a word-level model
module tb_ascon_permutation;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] state_in;
  logic [4:0]   rnd_in;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] state_out;
  logic         busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ascon_permutation #(.MAX_ROUNDS(16), .RND_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .rnd_in    (rnd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  // Reference: whole-word Ascon round using the boolean S-box formulation.
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [7:0] round_const(input int i);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(3 - i);
    lo = 4'(12 + i);
    return {hi, lo};
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int rnd);
    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [319:0] r;
    int eff;
    eff = (rnd > 16) ? 16 : rnd;
    for (int w = 0; w < 5; w++) x[w] = s[64*w +: 64];
    for (int i = 16 - eff; i < 16; i++) begin
      x[2] = x[2] ^ {56'h0, round_const(i)};
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    for (int w = 0; w < 5; w++) r[64*w +: 64] = x[w];
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Offer a job, wait for the accept, then count edges from the accept to out_valid.
  task automatic start_job(input logic [319:0] s, input logic [4:0] r, output int lat);
    int n;
    @(negedge clk);
    state_in = s;
    rnd_in   = r;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("ready_drop", in_ready, 0);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic take_output();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [319:0] s;
    logic [4:0]   rnd;
    logic [319:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat;
    int eff;
    logic [319:0] xs;
    logic [319:0] held;
    logic [319:0] sa;
    logic [319:0] sb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    state_in = '0; rnd_in = '0;

    vecs[0].s = '0;           vecs[0].rnd = 5'd12;
    vecs[1].s = rand_state(); vecs[1].rnd = 5'd8;
    vecs[2].s = '0;           vecs[2].rnd = 5'd1;
    vecs[3].s = rand_state(); vecs[3].rnd = 5'd0;
    xs = rand_state();
    vecs[4].s = xs;           vecs[4].rnd = 5'd16;
    vecs[5].s = xs;           vecs[5].rnd = 5'd20;
    for (int i = 6; i < 12; i++) begin
      vecs[i].s   = rand_state();
      vecs[i].rnd = 5'($urandom_range(0, 31));
    end
    for (int i = 0; i < 12; i++) begin
      eff = (vecs[i].rnd > 16) ? 16 : int'(vecs[i].rnd);
      vecs[i].exp = model_perm(vecs[i].s, int'(vecs[i].rnd));
      vecs[i].lat = eff + 1;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state_out", state_out, '0);

    for (int i = 0; i < 12; i++) begin
      start_job(vecs[i].s, vecs[i].rnd, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_result", i), state_out, vecs[i].exp);
      take_output();
    end

    // Output held off: result stable, new offers ignored.
    sa = rand_state();
    start_job(sa, 5'd6, lat);
    held = state_out;
    chk("hold_result", held, model_perm(sa, 6));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      state_in = rand_state();
      rnd_in   = 5'd3;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stable", state_out, held);
    end
    in_valid = 1'b0;
    take_output();
    @(negedge clk);
    chk("hold_released_ready", in_ready, 1);
    chk("hold_released_valid", out_valid, 0);

    // Reset while the fifth of twelve rounds is due.
    sa = rand_state();
    @(negedge clk);
    state_in = sa; rnd_in = 5'd12; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_in_ready", in_ready, 1);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_state", state_out, '0);
    sb = rand_state();
    start_job(sb, 5'd12, lat);
    chk("after_rst_latency", lat, 13);
    chk("after_rst_result", state_out, model_perm(sb, 12));
    take_output();

    // Back-to-back with out_ready high and the next job offered during DONE.
    sa = rand_state();
    sb = rand_state();
    start_job(sa, 5'd3, lat);
    chk("b2b_a_latency", lat, 4);
    chk("b2b_a_result", state_out, model_perm(sa, 3));
    out_ready = 1'b1;
    state_in = sb; rnd_in = 5'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_ready", in_ready, 1);
    chk("b2b_idle_valid", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("b2b_b_accepted", busy, 1);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_b_latency", lat, 6);
    chk("b2b_b_result", state_out, model_perm(sb, 5));
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_end_ready", in_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
